// File: rtl/ttpu_pkg.sv
// Shared types and helpers for the TTPU systolic compute core.
package ttpu_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  localparam int SAT_W = 128;

  // Arithmetic shift right by frac_w, then clamp to the signed data_w range.
  // Callers sign-extend their accumulator to SAT_W and truncate the result.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sh    = acc >>> frac_w;
    max_v = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (sh > max_v) return max_v;
    if (sh < min_v) return min_v;
    return sh;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: forwards a right and b down through a register each, and
// accumulates the full-width product into a wrapping accumulator.
module systolic_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   a_q, b_q;

  always_comb begin
    prod  = a_in * b_in;
    acc_d = acc_q;
    if (clear)       acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_in;
      b_q   <= b_in;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary DIMxDIM systolic matrix multiply with input skewing,
// runtime n/k_len, K-tile accumulation and valid/ready row streaming.
module systolic_mm_engine
  import ttpu_pkg::*;
#(
  parameter int DIM    = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC_W = 8,
  parameter int K_W    = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(DIM):0]         n,
  input  logic [K_W-1:0]               k_len,
  input  logic                         acc_keep,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIM-1:0][DATA_W-1:0]   a_col,
  input  logic [DIM-1:0][DATA_W-1:0]   b_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DIM-1:0][DATA_W-1:0]   out_row,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int NW = $clog2(DIM) + 1;
  localparam int RW = $clog2(DIM);
  localparam int DW = NW + 1;

  state_t         state_q;
  logic [NW-1:0]  n_q;
  logic [K_W-1:0] klen_q, step_q;
  logic [DW-1:0]  drain_q;
  logic [RW-1:0]  row_q;
  logic           in_ready_q, out_valid_q, busy_q, done_q, err_q;

  logic start_ok, clear_acc, acc_en, accept;

  assign start_ok  = (n != '0) && (n <= NW'(DIM)) && (k_len != '0);
  assign clear_acc = (state_q == IDLE) && start && start_ok && !acc_keep;
  assign acc_en    = (state_q == LOAD) || (state_q == DRAIN);
  assign accept    = in_ready_q && in_valid;

  // Lane entry: masked lanes and bubble cycles inject zero
  logic signed [DATA_W-1:0] a_inj  [DIM];
  logic signed [DATA_W-1:0] b_inj  [DIM];
  logic signed [DATA_W-1:0] a_lane [DIM];
  logic signed [DATA_W-1:0] b_lane [DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      if (accept && (i < int'(n_q))) begin
        a_inj[i] = $signed(a_col[i]);
        b_inj[i] = $signed(b_row[i]);
      end
    end
  end

  // Skew: lane i is delayed i registers so step k meets at PE(i,j) together
  for (genvar gi = 0; gi < DIM; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_lane[0] = a_inj[0];
      assign b_lane[0] = b_inj[0];
    end else begin : g_delay
      logic signed [DATA_W-1:0] a_sr_q [gi];
      logic signed [DATA_W-1:0] b_sr_q [gi];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < gi; d++) begin
            a_sr_q[d] <= '0;
            b_sr_q[d] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_inj[gi];
          b_sr_q[0] <= b_inj[gi];
          for (int d = 1; d < gi; d++) begin
            a_sr_q[d] <= a_sr_q[d-1];
            b_sr_q[d] <= b_sr_q[d-1];
          end
        end
      end
      assign a_lane[gi] = a_sr_q[gi-1];
      assign b_lane[gi] = b_sr_q[gi-1];
    end
  end

  // PE grid
  logic signed [DATA_W-1:0] a_o   [DIM][DIM];
  logic signed [DATA_W-1:0] b_o   [DIM][DIM];
  logic signed [ACC_W-1:0]  acc_w [DIM][DIM];

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      logic signed [DATA_W-1:0] a_pi, b_pi;
      if (gj == 0) begin : g_a_edge
        assign a_pi = a_lane[gi];
      end else begin : g_a_int
        assign a_pi = a_o[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_pi = b_lane[gj];
      end else begin : g_b_int
        assign b_pi = b_o[gi-1][gj];
      end
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_acc),
        .acc_en (acc_en),
        .a_in   (a_pi),
        .b_in   (b_pi),
        .a_out  (a_o[gi][gj]),
        .b_out  (b_o[gi][gj]),
        .acc_o  (acc_w[gi][gj])
      );
    end
  end

  // Output row mux: columns beyond n read zero
  always_comb begin
    out_row = '0;
    for (int j = 0; j < DIM; j++) begin
      if (out_valid_q && (j < int'(n_q)))
        out_row[j] = DATA_W'(sat_shift(SAT_W'(acc_w[row_q][j]), FRAC_W, DATA_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      n_q         <= '0;
      klen_q      <= '0;
      step_q      <= '0;
      drain_q     <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              n_q        <= n;
              klen_q     <= k_len;
              step_q     <= '0;
              state_q    <= LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            step_q <= step_q + K_W'(1);
            if (step_q == klen_q - K_W'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= '0;
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (drain_q == {n_q, 1'b0} - DW'(2)) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            row_q       <= '0;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (row_q == RW'(n_q - NW'(1))) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: randomized jobs checked against a matrix-level
// reference model of C = A*B with K-tile accumulation and output saturation.
module tb_systolic_mm_engine;

  localparam int DIM    = 8;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int FRAC_W = 8;
  localparam int K_W    = 10;
  localparam int KMAX   = 16;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       start;
  logic [3:0]                 n;
  logic [K_W-1:0]             k_len;
  logic                       acc_keep;
  logic                       in_valid;
  logic                       in_ready;
  logic [DIM-1:0][DATA_W-1:0] a_col;
  logic [DIM-1:0][DATA_W-1:0] b_row;
  logic                       out_valid;
  logic                       out_ready;
  logic [DIM-1:0][DATA_W-1:0] out_row;
  logic                       busy;
  logic                       done;
  logic                       err;

  systolic_mm_engine #(.DIM(DIM), .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_W(FRAC_W), .K_W(K_W)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .k_len(k_len), .acc_keep(acc_keep),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DATA_W-1:0] ga [DIM][KMAX];
  logic signed [DATA_W-1:0] gb [KMAX][DIM];
  longint m_acc [DIM][DIM];
  int     m_n;

  int   ob_ready, ob_lat, ob_done, ob_busy, ob_done2, ob_early, ob_stable, ob_timeout;
  logic [DATA_W-1:0] ob_rows [DIM][DIM];
  bit   chain_req = 1'b0;
  int   nx_n, nx_k;
  bit   nx_keep;

  function automatic longint wrap40(longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic logic [DATA_W-1:0] exp_out(int r, int j);
    longint s;
    if (j >= m_n || r >= m_n) return '0;
    s = m_acc[r][j] >>> FRAC_W;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return DATA_W'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(int nn, bit keep);
    m_n = nn;
    if (!keep)
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) m_acc[i][j] = 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < DIM; i++)
      for (int s = 0; s < KMAX; s++) begin
        ga[i][s] = DATA_W'($urandom);
        gb[s][i] = DATA_W'($urandom);
      end
  endtask

  // Runs one job end to end and records what the DUT did.
  task automatic do_job(int nn, int kk, bit keep, bit bub, bit stall, bit pre);
    int s, budget, t_last, t_out;
    bit tog, hs;
    logic [DIM-1:0][DATA_W-1:0] hold;
    ob_timeout = 0; ob_early = 0; ob_stable = 1; t_last = 0;
    if (!pre) begin
      start = 1; n = 4'(nn); k_len = K_W'(kk); acc_keep = keep;
      model_start(nn, keep);
      step();
      start = 0; n = 4'($urandom); k_len = K_W'($urandom); acc_keep = 1'($urandom);
    end
    ob_ready = int'(in_ready);
    s = 0; tog = 0; budget = 0;
    while (s < kk && budget < 1000) begin
      budget++;
      for (int i = 0; i < DIM; i++) begin
        a_col[i] = DATA_W'($urandom);
        b_row[i] = DATA_W'($urandom);
      end
      if (bub && tog) in_valid = 0;
      else begin
        in_valid = 1;
        for (int i = 0; i < nn; i++) begin
          a_col[i] = ga[i][s];
          b_row[i] = gb[s][i];
        end
        t_last = cyc;
      end
      tog = ~tog;
      hs = in_valid && in_ready;
      step();
      if (hs) begin
        for (int i = 0; i < nn; i++)
          for (int j = 0; j < nn; j++)
            m_acc[i][j] = wrap40(m_acc[i][j] + longint'(ga[i][s]) * longint'(gb[s][j]));
        s++;
      end
    end
    in_valid = 0;
    for (int i = 0; i < DIM; i++) begin
      a_col[i] = DATA_W'($urandom);
      b_row[i] = DATA_W'($urandom);
    end
    if (s < kk) ob_timeout = 1;
    budget = 0;
    while (!out_valid && budget < 100) begin
      if (done) ob_early = 1;
      step(); budget++;
    end
    if (!out_valid) ob_timeout = 1;
    t_out  = cyc;
    ob_lat = t_out - t_last;
    for (int r = 0; r < nn; r++) begin
      budget = 0;
      while (!out_valid && budget < 100) begin step(); budget++; end
      if (!out_valid) begin ob_timeout = 1; break; end
      if (stall) begin
        out_ready = 0;
        hold = out_row;
        repeat (3) begin
          step();
          if (out_row !== hold || !out_valid) ob_stable = 0;
        end
        out_ready = 1;
      end
      for (int j = 0; j < DIM; j++) ob_rows[r][j] = out_row[j];
      if (done) ob_early = 1;
      step();
    end
    ob_done = int'(done);
    ob_busy = int'(busy);
    if (chain_req) begin
      start = 1; n = 4'(nx_n); k_len = K_W'(nx_k); acc_keep = nx_keep;
      model_start(nx_n, nx_keep);
      chain_req = 0;
      step();
      start = 0;
    end else begin
      step();
    end
    ob_done2 = int'(done);
  endtask

  task automatic test_reset();
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (out_row !== '0)     begin n_fail++; $display("FAIL reset_out_row got %h want 0", out_row); end
    reset = 0;
    step();
  endtask

  task automatic test_identity();
    for (int i = 0; i < DIM; i++)
      for (int s = 0; s < KMAX; s++) begin
        ga[i][s] = (i == s) ? 16'sh0100 : 16'sh0000;
        gb[s][i] = DATA_W'(16'h0100 * (s + i));
      end
    do_job(4, 4, 0, 0, 0, 0);
    n_checks++; if (ob_ready !== 1)   begin n_fail++; $display("FAIL ident_in_ready got %0d want 1", ob_ready); end
    n_checks++; if (ob_lat !== 8)     begin n_fail++; $display("FAIL ident_latency got %0d want 8", ob_lat); end
    n_checks++; if (ob_timeout !== 0) begin n_fail++; $display("FAIL ident_timeout got %0d want 0", ob_timeout); end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < DIM; j++) begin
        n_checks++;
        if (ob_rows[r][j] !== ((j < 4) ? DATA_W'(16'h0100 * (r + j)) : 16'h0000)) begin
          n_fail++; $display("FAIL ident_row r%0d c%0d got %h want %h", r, j, ob_rows[r][j], exp_out(r, j));
        end
      end
    n_checks++; if (ob_done !== 1)  begin n_fail++; $display("FAIL ident_done got %0d want 1", ob_done); end
    n_checks++; if (ob_busy !== 0)  begin n_fail++; $display("FAIL ident_busy_at_done got %0d want 0", ob_busy); end
    n_checks++; if (ob_done2 !== 0) begin n_fail++; $display("FAIL ident_done_width got %0d want 0", ob_done2); end
    n_checks++; if (ob_early !== 0) begin n_fail++; $display("FAIL ident_early_done got %0d want 0", ob_early); end
  endtask

  task automatic test_bubbles_backpressure();
    do_job(4, 4, 0, 1, 1, 0);
    n_checks++; if (ob_timeout !== 0) begin n_fail++; $display("FAIL bub_timeout got %0d want 0", ob_timeout); end
    n_checks++; if (ob_lat !== 8)     begin n_fail++; $display("FAIL bub_latency got %0d want 8", ob_lat); end
    n_checks++; if (ob_stable !== 1)  begin n_fail++; $display("FAIL bub_row_stable got %0d want 1", ob_stable); end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < DIM; j++) begin
        n_checks++;
        if (ob_rows[r][j] !== exp_out(r, j)) begin
          n_fail++; $display("FAIL bub_row r%0d c%0d got %h want %h", r, j, ob_rows[r][j], exp_out(r, j));
        end
      end
    n_checks++; if (ob_done !== 1) begin n_fail++; $display("FAIL bub_done got %0d want 1", ob_done); end
  endtask

  task automatic test_k_tiling();
    for (int i = 0; i < DIM; i++)
      for (int s = 0; s < KMAX; s++) begin ga[i][s] = 16'sh0100; gb[s][i] = 16'sh0100; end
    for (int job = 0; job < 2; job++) begin
      do_job(2, 3, job[0], 0, 0, 0);
      for (int r = 0; r < 2; r++)
        for (int j = 0; j < 3; j++) begin
          n_checks++;
          if (ob_rows[r][j] !== ((j < 2) ? ((job == 0) ? 16'h0300 : 16'h0600) : 16'h0000)) begin
            n_fail++; $display("FAIL ktile job%0d r%0d c%0d got %h want %h", job, r, j, ob_rows[r][j], exp_out(r, j));
          end
        end
    end
  endtask

  task automatic test_saturation();
    for (int s = 0; s < KMAX; s++) begin ga[0][s] = 16'sh7FFF; gb[s][0] = 16'sh7FFF; end
    do_job(1, 4, 0, 0, 0, 0);
    n_checks++; if (ob_rows[0][0] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos got %h want 7fff", ob_rows[0][0]); end
    for (int s = 0; s < KMAX; s++) ga[0][s] = 16'sh8000;
    do_job(1, 4, 0, 0, 0, 0);
    n_checks++; if (ob_rows[0][0] !== 16'h8000) begin n_fail++; $display("FAIL sat_neg got %h want 8000", ob_rows[0][0]); end
  endtask

  task automatic test_illegal_edge();
    int bad_n [3] = '{0, DIM + 1, 2};
    int bad_k [3] = '{3, 3, 0};
    for (int t = 0; t < 3; t++) begin
      start = 1; n = 4'(bad_n[t]); k_len = K_W'(bad_k[t]); acc_keep = 0;
      step();
      start = 0;
      n_checks++; if (err !== 1'b1)      begin n_fail++; $display("FAIL illegal%0d_err got %b want 1", t, err); end
      n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL illegal%0d_busy got %b want 0", t, busy); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL illegal%0d_in_ready got %b want 0", t, in_ready); end
      step();
      n_checks++; if (err !== 1'b0)      begin n_fail++; $display("FAIL illegal%0d_err_width got %b want 0", t, err); end
    end
    ga[0][0] = 16'sh0200; gb[0][0] = 16'sh0300;
    do_job(1, 1, 0, 0, 0, 0);
    n_checks++; if (ob_lat !== 2) begin n_fail++; $display("FAIL edge_latency got %0d want 2", ob_lat); end
    for (int j = 0; j < DIM; j++) begin
      n_checks++;
      if (ob_rows[0][j] !== ((j == 0) ? 16'h0600 : 16'h0000)) begin
        n_fail++; $display("FAIL edge_row c%0d got %h want %h", j, ob_rows[0][j], exp_out(0, j));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    bit saw_done;
    fill_rand();
    start = 1; n = 4'(DIM); k_len = K_W'(2); acc_keep = 0;
    step();
    start = 0;
    for (int s = 0; s < 2; s++) begin
      in_valid = 1;
      for (int i = 0; i < DIM; i++) begin a_col[i] = ga[i][s]; b_row[i] = gb[s][i]; end
      step();
    end
    in_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_row !== '0)     begin n_fail++; $display("FAIL rst_out_row got %h want 0", out_row); end
    saw_done = 0;
    repeat (30) begin
      if (done) saw_done = 1;
      step();
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_stale_done got %b want 0", saw_done); end
    model_start(DIM, 0);
    fill_rand();
    do_job(3, 5, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++)
      for (int j = 0; j < DIM; j++) begin
        n_checks++;
        if (ob_rows[r][j] !== exp_out(r, j)) begin
          n_fail++; $display("FAIL rst_job r%0d c%0d got %h want %h", r, j, ob_rows[r][j], exp_out(r, j));
        end
      end
    n_checks++; if (ob_early !== 0) begin n_fail++; $display("FAIL rst_job_early_done got %0d want 0", ob_early); end
  endtask

  task automatic test_back_to_back();
    fill_rand();
    chain_req = 1; nx_n = 2; nx_k = 3; nx_keep = 0;
    do_job(3, 3, 0, 0, 0, 0);
    n_checks++; if (ob_done !== 1) begin n_fail++; $display("FAIL b2b_first_done got %0d want 1", ob_done); end
    fill_rand();
    do_job(2, 3, 0, 0, 0, 1);
    n_checks++; if (ob_ready !== 1) begin n_fail++; $display("FAIL b2b_start_accepted got %0d want 1", ob_ready); end
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < DIM; j++) begin
        n_checks++;
        if (ob_rows[r][j] !== exp_out(r, j)) begin
          n_fail++; $display("FAIL b2b_row r%0d c%0d got %h want %h", r, j, ob_rows[r][j], exp_out(r, j));
        end
      end
  endtask

  task automatic test_random();
    int nn, kk;
    bit keep, bub, stl;
    for (int t = 0; t < 8; t++) begin
      nn = $urandom_range(1, DIM); kk = $urandom_range(1, 12);
      keep = 1'($urandom); bub = 1'($urandom); stl = 1'($urandom);
      fill_rand();
      do_job(nn, kk, keep, bub, stl, 0);
      n_checks++; if (ob_lat !== 2 * nn) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", t, ob_lat, 2 * nn); end
      n_checks++; if (ob_stable !== 1)   begin n_fail++; $display("FAIL rand%0d_stable got %0d want 1", t, ob_stable); end
      n_checks++; if (ob_done !== 1 || ob_done2 !== 0 || ob_early !== 0) begin
        n_fail++; $display("FAIL rand%0d_done got %0d%0d%0d want 100", t, ob_done, ob_done2, ob_early);
      end
      for (int r = 0; r < nn; r++)
        for (int j = 0; j < DIM; j++) begin
          n_checks++;
          if (ob_rows[r][j] !== exp_out(r, j)) begin
            n_fail++; $display("FAIL rand%0d_row r%0d c%0d got %h want %h", t, r, j, ob_rows[r][j], exp_out(r, j));
          end
        end
    end
  endtask

  initial begin
    reset = 1; start = 0; n = '0; k_len = '0; acc_keep = 0;
    in_valid = 0; a_col = '0; b_row = '0; out_ready = 1;
    model_start(DIM, 0);
    repeat (3) step();
    test_reset();
    test_identity();
    test_bubbles_backpressure();
    test_k_tiling();
    test_saturation();
    test_illegal_edge();
    test_reset_mid_drain();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle %0d reached without completing", cyc);
    $fatal(1, "watchdog");
  end

endmodule
